// File: rtl/adc_block_accumulator.sv
// adc_block_accumulator
// Sums blocks of 2**LOG2_N consecutive ADC samples from one channel into an
// ACC_W-bit block sum. The sum is presented in an output register behind a
// valid/ready handshake. Blocks are accumulated back-to-back with no gap.
//
// Optional feature macro: OVERRUN_CNT_EN
//   When it is defined, the module has an extra 8-bit port, overrun_cnt. This
//   port holds a saturating count of overrun pulses and is cleared only by rst.
//
// Handshake: acc_out/acc_valid form the producer side. A block sum is
// transferred in any cycle where acc_valid && acc_ready. While acc_valid is 1
// and acc_ready is 0, acc_out is held stable. A block that completes while the
// output register is still full and not being consumed is dropped, and
// overrun pulses for one cycle.
module adc_block_accumulator #(
  parameter int SAMPLE_W = 12,
  parameter int LOG2_N   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [SAMPLE_W-1:0]          sample_in,
  input  logic                         sample_valid,
  output logic [SAMPLE_W+LOG2_N-1:0]   acc_out,
  output logic                         acc_valid,
  input  logic                         acc_ready,
  output logic                         busy,
  output logic                         overrun
`ifdef OVERRUN_CNT_EN
  ,
  output logic [7:0]                   overrun_cnt
`endif
);

  localparam int ACC_W = SAMPLE_W + LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_ONE = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [LOG2_N-1:0] cnt;

  logic              accept;
  logic              block_done;
  logic              load_ok;
  logic [ACC_W-1:0]  sum;

  // Sample qualification, block-complete detection and the running sum.
  always_comb begin
    accept     = 1'b0;
    block_done = 1'b0;
    load_ok    = 1'b0;
    sum        = '0;
    accept     = (state == RUN) && enable && sample_valid;
    // cnt all-ones means this accepted sample is the last one of the block
    block_done = accept && (&cnt);
    load_ok    = !acc_valid || acc_ready;
    sum        = acc + {{LOG2_N{1'b0}}, sample_in};
  end

  // Control FSM, accumulator, and output register with its handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (enable) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            // abort: the partial block is discarded, the output register is kept
            state <= IDLE;
            busy  <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
          end else if (sample_valid) begin
            if (&cnt) begin
              acc <= '0;
              cnt <= '0;
            end else begin
              acc <= sum;
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // A completion takes priority over a plain consume. Loading in the same
      // cycle as a consume keeps acc_valid high with the new sum.
      if (block_done) begin
        if (load_ok) begin
          acc_out   <= sum;
          acc_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (acc_valid && acc_ready) begin
        acc_valid <= 1'b0;
      end
    end
  end

`ifdef OVERRUN_CNT_EN
  // Saturating count of dropped blocks; sticks at 255 until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_cnt <= '0;
    end else if (block_done && !load_ok && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adc_block_accumulator.sv
// tb_adc_block_accumulator
// Directed scenarios, followed by randomized traffic, checked every cycle
// against a queue-based block-sum reference model.
module tb_adc_block_accumulator;

  localparam int SAMPLE_W = 12;
  localparam int LOG2_N   = 8;
  localparam int N        = 1 << LOG2_N;
  localparam int ACC_W    = SAMPLE_W + LOG2_N;

  logic                clk;
  logic                rst;
  logic                enable;
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic [ACC_W-1:0]    acc_out;
  logic                acc_valid;
  logic                acc_ready;
  logic                busy;
  logic                overrun;
`ifdef OVERRUN_CNT_EN
  logic [7:0]          overrun_cnt;
`endif

  int n_vec;
  int n_err;

  // Reference model state.
  bit               m_run;
  int               blk_q[$];
  logic [ACC_W-1:0] m_out;
  bit               m_vld;
  bit               m_ovr;
  int               m_ocnt;

  adc_block_accumulator #(.SAMPLE_W(SAMPLE_W), .LOG2_N(LOG2_N)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .acc_out      (acc_out),
    .acc_valid    (acc_valid),
    .acc_ready    (acc_ready),
    .busy         (busy),
    .overrun      (overrun)
`ifdef OVERRUN_CNT_EN
    ,
    .overrun_cnt  (overrun_cnt)
`endif
  );

  // clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. It advances one clock using the rules for blocks and the
  // output slot. The samples of the current block are kept in a queue, and the
  // queue is summed when it reaches N entries.
  task automatic model_step(input bit r, input bit en, input bit sv,
                            input int s, input bit rdy);
    bit done;
    int total;
    done = 0;
    total = 0;
    if (r) begin
      m_run = 0; blk_q.delete(); m_out = '0; m_vld = 0; m_ovr = 0; m_ocnt = 0;
      return;
    end
    m_ovr = 0;
    if (!m_run) begin
      if (en) m_run = 1;
    end else if (!en) begin
      m_run = 0;
      blk_q.delete();
    end else if (sv) begin
      blk_q.push_back(s);
      if (blk_q.size() == N) begin
        foreach (blk_q[i]) total += blk_q[i];
        blk_q.delete();
        done = 1;
      end
    end
    if (done) begin
      if (!m_vld || rdy) begin
        m_out = total[ACC_W-1:0];
        m_vld = 1;
      end else begin
        m_ovr = 1;
        if (m_ocnt < 255) m_ocnt++;
      end
    end else if (m_vld && rdy) begin
      m_vld = 0;
    end
  endtask

  // driver: drive one cycle at the falling edge, then compare just after the rising edge
  task automatic tick(input bit r, input bit en, input bit sv, input int s, input bit rdy);
    @(negedge clk);
    rst = r; enable = en; sample_valid = sv; sample_in = s[SAMPLE_W-1:0]; acc_ready = rdy;
    model_step(r, en, sv, s, rdy);
    @(posedge clk);
    #1;
    check("acc_out",   32'(acc_out),   32'(m_out));
    check("acc_valid", 32'(acc_valid), 32'(m_vld));
    check("busy",      32'(busy),      32'(m_run));
    check("overrun",   32'(overrun),   32'(m_ovr));
`ifdef OVERRUN_CNT_EN
    check("overrun_cnt", 32'(overrun_cnt), 32'(m_ocnt));
`endif
  endtask

  task automatic feed(input int n, input int v, input bit rdy);
    for (int i = 0; i < n; i++) tick(0, 1, 1, v, rdy);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1; enable = 0; sample_valid = 0; sample_in = '0; acc_ready = 0;

    // reset state
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check("rst_out", 32'(acc_out), 32'h0);
    check("rst_valid", 32'(acc_valid), 32'h0);

    // all-ones samples: maximum block sum, valid one cycle after the last sample
    tick(0, 1, 1, 12'h123, 1);   // IDLE -> RUN; this sample is ignored
    feed(N - 1, 12'hFFF, 1);
    check("max_pre_valid", 32'(acc_valid), 32'h0);
    tick(0, 1, 1, 12'hFFF, 1);
    check("max_sum", 32'(acc_out), 32'hFFF00);
    check("max_valid", 32'(acc_valid), 32'h1);
    check("max_ovr", 32'(overrun), 32'h0);

    // ramp with sample_valid toggling every other cycle, then a block of ones
    for (int i = 0; i < N; i++) begin
      tick(0, 1, 1, i, 1);
      tick(0, 1, 0, 12'hABC, 1);
    end
    check("ramp_sum", 32'(acc_out), 32'h07F80);
    feed(N, 1, 1);
    check("ones_sum", 32'(acc_out), 32'h00100);

    // consume, then two blocks with ready low: the second one is dropped
    tick(0, 1, 0, 0, 1);
    feed(N, 1, 0);
    check("hold_sum", 32'(acc_out), 32'h00100);
    feed(N, 1, 0);
    check("ovr_pulse", 32'(overrun), 32'h1);
    check("ovr_hold", 32'(acc_out), 32'h00100);
    tick(0, 1, 0, 0, 0);
    check("ovr_end", 32'(overrun), 32'h0);

    // ready is raised in the exact cycle the next block completes
    feed(N - 1, 2, 0);
    tick(0, 1, 1, 2, 1);
    check("swap_sum", 32'(acc_out), 32'h00200);
    check("swap_valid", 32'(acc_valid), 32'h1);
    check("swap_ovr", 32'(overrun), 32'h0);

    // abort a partial block by dropping enable
    tick(0, 1, 0, 0, 1);
    feed(100, 12'h010, 1);
    tick(0, 0, 1, 12'h010, 1);
    check("abort_busy", 32'(busy), 32'h0);
    tick(0, 1, 1, 12'h010, 1);
    feed(N, 1, 1);
    check("abort_sum", 32'(acc_out), 32'h00100);

    // reset mid-block while the output is full
    feed(50, 3, 0);
    tick(1, 1, 1, 3, 0);
    check("mrst_out", 32'(acc_out), 32'h0);
    check("mrst_valid", 32'(acc_valid), 32'h0);
    check("mrst_busy", 32'(busy), 32'h0);
    tick(0, 1, 0, 0, 0);
    feed(N, 3, 0);
    check("post_rst_sum", 32'(acc_out), 32'h00300);

    // randomized traffic
    for (int i = 0; i < 6000; i++) begin
      tick(($urandom_range(0, 2999) == 0),
           ($urandom_range(0, 299) != 0),
           ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 4095)),
           ($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
